// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, next-PC
// source codes, default memory timeout and the next-PC selection rule.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;  // PC + 4
  localparam logic [1:0] PCSEL_IMM = 2'b01;  // PC + imm
  localparam logic [1:0] PCSEL_ALU = 2'b10;  // ALU result

  localparam int DEFAULT_TIMEOUT = 16;

  // Register-indirect jumps win over PC-relative jumps and taken branches.
  function automatic logic [1:0] pc_sel_f(input logic jumpr, input logic jump,
                                          input logic branch, input logic taken);
    if (jumpr) return PCSEL_ALU;
    if (jump || (branch && taken)) return PCSEL_IMM;
    return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts consecutive cycles a memory request goes without acknowledgement and
// flags expiry on the cycle that completes TIMEOUT unacknowledged cycles.
module wait_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry forces a state change, which clears the count before it can pass LAST.
  assign expired_o = tick_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Control sequencer for a multicycle CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and halts on protocol faults.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_jump_i,
  input  logic        cs_jumpr_i,
  input  logic        cs_branch_i,
  input  logic        cs_memrd_i,
  input  logic        cs_memwrt_i,
  input  logic        cs_regwrt_i,
  input  logic        br_taken_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic        ir_en_o,
  output logic        pc_en_o,
  output logic [1:0]  pc_sel_o,
  output logic        reg_we_o,
  output logic        err_o,
  output logic [2:0]  state_o,
  output logic [31:0] retired_o
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        wait_clear, wait_tick, wait_expired;
  logic        pc_en;

  assign wait_tick  = ((state_q == ST_FETCH) && !imem_ack_i) ||
                      ((state_q == ST_MEM)   && !dmem_ack_i);
  assign wait_clear = (state_d != state_q);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wait_clear),
    .tick_i    (wait_tick),
    .expired_o (wait_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack_i)        state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (cs_memrd_i && cs_memwrt_i)      state_d = ST_HALT;
        else if (cs_memrd_i || cs_memwrt_i) state_d = ST_MEM;
        else if (cs_regwrt_i)               state_d = ST_WB;
        else                                state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (dmem_ack_i)        state_d = cs_memwrt_i ? ST_FETCH : ST_WB;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  // Strobes are held low while reset is asserted so an abandoned instruction never retires.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_en_o    = 1'b0;
    pc_en      = 1'b0;
    reg_we_o   = 1'b0;
    err_o      = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req_o = 1'b1;
          ir_en_o    = imem_ack_i;
        end
        ST_EXEC:  pc_en = !cs_memrd_i && !cs_memwrt_i && !cs_regwrt_i;
        ST_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = cs_memwrt_i;
          pc_en      = dmem_ack_i && cs_memwrt_i;
        end
        ST_WB: begin
          reg_we_o = 1'b1;
          pc_en    = 1'b1;
        end
        ST_HALT:  err_o = 1'b1;
        default:  ;
      endcase
    end
    pc_en_o  = pc_en;
    pc_sel_o = pc_en ? pc_sel_f(cs_jumpr_i, cs_jump_i, cs_branch_i, br_taken_i)
                     : PCSEL_SEQ;
  end

  always_comb begin
    retired_d = pc_en ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule
